// File: rtl/pipeline_sequencer_if.sv
// Control/hazard bundle between the pipeline datapath/debug side (master)
// and the pipeline sequencer (slave).
interface pipeline_sequencer_if #(
  parameter int NB_REG   = 5,
  parameter int NB_CYCLE = 32
);
  logic                i_run;
  logic                i_step;
  logic                i_halt_instr;
  logic [NB_REG-1:0]   ID_rs;
  logic [NB_REG-1:0]   ID_rt;
  logic                EX_mem_read;
  logic [NB_REG-1:0]   EX_rt;
  logic                MEM_branch_taken;

  logic                o_pipe_en;
  logic                o_pc_en;
  logic                o_IF_ID_en;
  logic                o_IF_ID_flush;
  logic                o_ID_EX_flush;
  logic                o_EX_MEM_flush;
  logic [1:0]          o_state;
  logic                o_halted;
  logic [NB_CYCLE-1:0] o_cycle_count;
  logic [NB_CYCLE-1:0] o_stall_count;

  modport master (
    output i_run, i_step, i_halt_instr, ID_rs, ID_rt, EX_mem_read, EX_rt, MEM_branch_taken,
    input  o_pipe_en, o_pc_en, o_IF_ID_en, o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush,
           o_state, o_halted, o_cycle_count, o_stall_count
  );

  modport slave (
    input  i_run, i_step, i_halt_instr, ID_rs, ID_rt, EX_mem_read, EX_rt, MEM_branch_taken,
    output o_pipe_en, o_pc_en, o_IF_ID_en, o_IF_ID_flush, o_ID_EX_flush, o_EX_MEM_flush,
           o_state, o_halted, o_cycle_count, o_stall_count
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer for the 5-stage pipeline with load-use stall and branch flush.
// Define STALL_COUNTER_EN to build the saturating load-use stall counter.
module pipeline_sequencer #(
  parameter int NB_REG   = 5,
  parameter int NB_CYCLE = 32
) (
  input logic                 i_clock,
  input logic                 i_reset,
  pipeline_sequencer_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;
  localparam logic [NB_CYCLE-1:0] CNT_MAX = '1;

  function automatic logic [NB_CYCLE-1:0] sat_inc(input logic [NB_CYCLE-1:0] v);
    return (v == CNT_MAX) ? v : v + NB_CYCLE'(1);
  endfunction

  logic [1:0]          state;
  logic [1:0]          state_nxt;
  logic                pipe_en;
  logic                stall;
  logic [NB_REG-1:0]   id_rs;
  logic [NB_REG-1:0]   id_rt;
  logic [NB_REG-1:0]   ex_rt;
  logic [NB_CYCLE-1:0] cycle_cnt;

  assign id_rs = bus.ID_rs;
  assign id_rt = bus.ID_rt;
  assign ex_rt = bus.EX_rt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (bus.i_run)       state_nxt = ST_RUN;
        else if (bus.i_step) state_nxt = ST_STEP;
      end
      ST_RUN:  if (bus.i_halt_instr) state_nxt = ST_HALTED;
      ST_STEP: state_nxt = bus.i_halt_instr ? ST_HALTED : ST_IDLE;
      default: state_nxt = ST_HALTED;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  assign pipe_en = (state == ST_RUN) | (state == ST_STEP);

  // Hazard stage: same-cycle decode, branch flush takes precedence over a load-use stall
  assign stall = bus.EX_mem_read & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

  always_comb begin
    bus.o_pc_en        = 1'b0;
    bus.o_IF_ID_en     = 1'b0;
    bus.o_IF_ID_flush  = 1'b0;
    bus.o_ID_EX_flush  = 1'b0;
    bus.o_EX_MEM_flush = 1'b0;
    if (pipe_en) begin
      if (bus.MEM_branch_taken) begin
        bus.o_pc_en        = 1'b1;
        bus.o_IF_ID_en     = 1'b1;
        bus.o_IF_ID_flush  = 1'b1;
        bus.o_ID_EX_flush  = 1'b1;
        bus.o_EX_MEM_flush = 1'b1;
      end else if (stall) begin
        bus.o_ID_EX_flush  = 1'b1;
      end else begin
        bus.o_pc_en        = 1'b1;
        bus.o_IF_ID_en     = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)      cycle_cnt <= '0;
    else if (pipe_en) cycle_cnt <= sat_inc(cycle_cnt);
  end

`ifdef STALL_COUNTER_EN
  logic [NB_CYCLE-1:0] stall_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset)                                      stall_cnt <= '0;
    else if (pipe_en & stall & ~bus.MEM_branch_taken) stall_cnt <= sat_inc(stall_cnt);
  end

  assign bus.o_stall_count = stall_cnt;
`else
  assign bus.o_stall_count = '0;
`endif

  assign bus.o_pipe_en     = pipe_en;
  assign bus.o_state       = state;
  assign bus.o_halted      = (state == ST_HALTED);
  assign bus.o_cycle_count = cycle_cnt;
endmodule
